spi_req_scheduler: RTL and testbench
====================================

// Module: spi_req_scheduler
// PURPOSE
//  Shares one spi_top master among NUM_REQ requesters using round-robin arbitration.
//  For each granted request it drives spi_top req/din_master/wait_duration and waits
//    for done_tx/done_rx as required by the mode.
//  It returns the received word to the requester, then enforces an idle gap before
//    the next grant. It sits between the host-side clients and spi_top.
// PARAMETERS
//  NUM_REQ        4       number of requesters (2..8)
//  DATA_W         8       SPI word width; equals spi_top SPI_TRF_BIT
//  GAP_CYCLES     4       idle clk cycles between transactions (>=1)
//  TIMEOUT        4096    clk cycles allowed from issue to completion
//  WAIT_DURATION  10      value driven on spi_wait_duration
// PORTS
//  clk               in   1             system clock
//  rst               in   1             synchronous reset, active-high
//  rq_valid          in   NUM_REQ       request pending, one bit per requester
//  rq_mode           in   2*NUM_REQ     per-requester mode: 01 tx, 10 rx, 11 full duplex, 00 illegal
//  rq_data           in   DATA_W*NUM_REQ per-requester tx word
//  rq_ready          out  NUM_REQ       one-hot accept pulse
//  rsp_valid         out  NUM_REQ       one-hot completion pulse
//  rsp_data          out  DATA_W        rx word, valid with rsp_valid
//  rsp_err           out  1             error flag, valid with rsp_valid
//  busy              out  1             high in any state other than IDLE
//  spi_req           out  2             to spi_top req
//  spi_din           out  DATA_W        to spi_top din_master
//  spi_wait_duration out  8             to spi_top wait_duration, constant WAIT_DURATION
//  spi_idle          in   1             spi_top master and slave FSMs all idle
//  spi_done_tx       in   1             spi_top done_tx
//  spi_done_rx       in   1             spi_top done_rx
//  spi_dout          in   DATA_W        spi_top dout_master
// BEHAVIOUR
//  Reset: all outputs 0 except spi_wait_duration; state IDLE; rr_ptr=NUM_REQ-1;
//    counters and done flags cleared. Reset mid-transaction drops it, no rsp_valid.
//  FSM states: IDLE, ISSUE, GAP.
//  IDLE: if |rq_valid && spi_idle, winner = first set bit searching rr_ptr+1 upward, wrapping.
//    rq_ready[winner]=1 combinationally that cycle.
//    On that edge: capture mode/data/index, set rr_ptr=winner.
//    Mode 00: next cycle rsp_valid=1, rsp_err=1, rsp_data=0; go to GAP; no SPI activity.
//    Otherwise go to ISSUE. No grant while spi_idle=0.
//  ISSUE: spi_req=mode and spi_din=data held stable every cycle.
//    Sticky flags tx_seen/rx_seen set on spi_done_tx/spi_done_rx; both may set in one cycle.
//    rsp_data captures spi_dout on the cycle spi_done_rx=1.
//    Complete when 01:tx_seen, 10:rx_seen, 11:both (flags included in same-cycle evaluation).
//    Next cycle: rsp_valid[idx]=1 for 1 cycle, rsp_err=0, spi_req=00; go to GAP.
//    Mode 01: rsp_data=0.
//  Timeout: issue counter starts at 0 on ISSUE entry.
//    If it reaches TIMEOUT-1 without completion: rsp_valid=1, rsp_err=1, rsp_data=0;
//      spi_req=00; go to GAP.
//    Completion on the same cycle as the timeout wins: rsp_err=0.
//  GAP: spi_req=00; count GAP_CYCLES cycles, then return to IDLE once spi_idle=1.
//  rq_valid drop after rq_ready is ignored. Requester holds rq_valid/mode/data until rq_ready.
//  Done pulses seen outside ISSUE are ignored.
// TESTING
//  Single req0 mode01 data 8'hA5 -> rq_ready[0] pulse; spi_req=01; slave dout=A5;
//    rsp_valid[0], rsp_data=0, rsp_err=0.
//  req1 mode10, slave din=8'h3C -> rsp_valid[1], rsp_data=3C; spi_req=00 on next cycle.
//  rq_valid=4'b1111 held -> grants 0,1,2,3,0 in order, each separated by >=GAP_CYCLES idle cycles.
//  Mode 11 with done_tx and done_rx arriving in the same cycle, and again 20 cycles apart
//    -> exactly one rsp_valid each time.
//  TIMEOUT=64, spi_idle forced 1, no done pulses -> rsp_err=1 at issue+64; then GAP, IDLE.
//  rst pulsed mid-ISSUE -> all outputs 0 next cycle, no rsp_valid; next grant goes to req0.

Source files
------------

// File: rtl/spi_req_scheduler.sv
// spi_req_scheduler
//   Shares a single spi_top master among NUM_REQ requesters with round-robin
//   arbitration. A granted request is issued to spi_top until the done pulses
//   required by its mode arrive, or until the issue timeout expires. The result
//   is returned to the requester as a one-cycle response. An idle gap of at
//   least GAP_CYCLES cycles is then enforced before the next grant.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   rq_valid            per-requester request pending
//   rq_mode             per-requester mode, 2 bits each: 01 tx, 10 rx, 11 duplex, 00 illegal
//   rq_data             per-requester tx word, DATA_W bits each
//   rq_ready            one-hot accept pulse, combinational in IDLE
//   rsp_valid           one-hot completion pulse
//   rsp_data, rsp_err   response word and error flag, valid with rsp_valid
//   busy                high whenever the scheduler is not in IDLE
//   spi_req, spi_din    request mode and tx word towards spi_top
//   spi_wait_duration   constant WAIT_DURATION towards spi_top
//   spi_idle            spi_top master and slave FSMs are idle
//   spi_done_tx/rx      spi_top completion pulses
//   spi_dout            spi_top received word
module spi_req_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int GAP_CYCLES    = 4,
    parameter int TIMEOUT       = 4096,
    parameter int WAIT_DURATION = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          rq_valid,
    input  logic [2*NUM_REQ-1:0]        rq_mode,
    input  logic [DATA_W*NUM_REQ-1:0]   rq_data,
    output logic [NUM_REQ-1:0]          rq_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [1:0]                  spi_req,
    output logic [DATA_W-1:0]           spi_din,
    output logic [7:0]                  spi_wait_duration,
    input  logic                        spi_idle,
    input  logic                        spi_done_tx,
    input  logic                        spi_done_rx,
    input  logic [DATA_W-1:0]           spi_dout
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  cur_idx;
    logic [1:0]        cur_mode;
    logic [DATA_W-1:0] cur_data;
    logic [DATA_W-1:0] rx_word;
    logic              tx_seen;
    logic              rx_seen;
    logic [CNT_W-1:0]  cnt;

    logic              found;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  cand;
    logic [1:0]        win_mode;
    logic [DATA_W-1:0] win_data;
    logic              grant;
    logic              tx_now;
    logic              rx_now;
    logic              complete;

    // Round-robin search: the requester just after the last winner has the
    // highest priority, wrapping around the requester list.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr) + 32'(i)) % NUM_REQ);
            if (!found && rq_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_mode = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                win_mode = rq_mode[2*i +: 2];
                win_data = rq_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Grant is suppressed during reset so that every output reads zero.
    assign grant    = (state == ST_IDLE) && found && spi_idle && !rst;
    assign rq_ready = grant ? (NUM_REQ'(1) << winner) : '0;

    // Completion includes done pulses arriving in the evaluation cycle itself.
    always_comb begin
        tx_now = tx_seen | spi_done_tx;
        rx_now = rx_seen | spi_done_rx;
        case (cur_mode)
            2'b01:   complete = tx_now;
            2'b10:   complete = rx_now;
            2'b11:   complete = tx_now & rx_now;
            default: complete = 1'b0;
        endcase
    end

    assign busy              = (state != ST_IDLE);
    assign spi_req           = (state == ST_ISSUE) ? cur_mode : 2'b00;
    assign spi_din           = (state == ST_ISSUE) ? cur_data : '0;
    assign spi_wait_duration = 8'(WAIT_DURATION);

    // cnt counts issue cycles in ISSUE and gap cycles in GAP; it restarts at 0
    // on every state change. Response outputs are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            cur_idx   <= '0;
            cur_mode  <= 2'b00;
            cur_data  <= '0;
            rx_word   <= '0;
            tx_seen   <= 1'b0;
            rx_seen   <= 1'b0;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        cur_mode <= win_mode;
                        cur_data <= win_data;
                        cur_idx  <= winner;
                        rr_ptr   <= winner;
                        tx_seen  <= 1'b0;
                        rx_seen  <= 1'b0;
                        cnt      <= '0;
                        if (win_mode == 2'b00) begin
                            rsp_valid <= NUM_REQ'(1) << winner;
                            rsp_err   <= 1'b1;
                            state     <= ST_GAP;
                        end else begin
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (spi_done_tx) begin
                        tx_seen <= 1'b1;
                    end
                    if (spi_done_rx) begin
                        rx_seen <= 1'b1;
                        rx_word <= spi_dout;
                    end
                    if (complete) begin
                        rsp_valid <= NUM_REQ'(1) << cur_idx;
                        if (cur_mode != 2'b01) begin
                            rsp_data <= spi_done_rx ? spi_dout : rx_word;
                        end
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid <= NUM_REQ'(1) << cur_idx;
                        rsp_err   <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    // The counter saturates once the minimum gap is met and
                    // the FSM then waits for spi_top to report idle.
                    if (cnt >= CNT_W'(GAP_CYCLES - 1)) begin
                        if (spi_idle) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_scheduler.sv
// tb_spi_req_scheduler
//   Self-checking bench for spi_req_scheduler. The bench plays spi_top and the
//   requesters, and predicts each transaction from its rules: round-robin winner,
//   grant latency after the gap, response cycle from the done-pulse schedule or
//   the timeout, and the response word and error flag.
module tb_spi_req_scheduler;

    localparam int NUM_REQ       = 4;
    localparam int DATA_W        = 8;
    localparam int GAP_CYCLES    = 4;
    localparam int TIMEOUT       = 64;
    localparam int WAIT_DURATION = 10;
    localparam int NEVER         = 1000000;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        rq_valid;
    logic [2*NUM_REQ-1:0]      rq_mode;
    logic [DATA_W*NUM_REQ-1:0] rq_data;
    logic [NUM_REQ-1:0]        rq_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic                      busy;
    logic [1:0]                spi_req;
    logic [DATA_W-1:0]         spi_din;
    logic [7:0]                spi_wait_duration;
    logic                      spi_idle;
    logic                      spi_done_tx;
    logic                      spi_done_rx;
    logic [DATA_W-1:0]         spi_dout;

    always #5 clk = ~clk;

    spi_req_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .DATA_W        (DATA_W),
        .GAP_CYCLES    (GAP_CYCLES),
        .TIMEOUT       (TIMEOUT),
        .WAIT_DURATION (WAIT_DURATION)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rq_valid          (rq_valid),
        .rq_mode           (rq_mode),
        .rq_data           (rq_data),
        .rq_ready          (rq_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .rsp_err           (rsp_err),
        .busy              (busy),
        .spi_req           (spi_req),
        .spi_din           (spi_din),
        .spi_wait_duration (spi_wait_duration),
        .spi_idle          (spi_idle),
        .spi_done_tx       (spi_done_tx),
        .spi_done_rx       (spi_done_rx),
        .spi_dout          (spi_dout)
    );

    int errors = 0;
    int checks = 0;

    // Requester model: pending flag, mode and word per requester.
    bit         pend  [NUM_REQ];
    logic [1:0] pmode [NUM_REQ];
    logic [7:0] pdata [NUM_REQ];

    int last_winner;
    int cyc_r;
    int idle_low;
    int exp_wait;
    bit noise;
    logic [NUM_REQ-1:0] seen_ready;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic driveReqs();
        for (int k = 0; k < NUM_REQ; k++) begin
            rq_valid[k]                  = pend[k];
            rq_mode[2*k +: 2]            = pmode[k];
            rq_data[DATA_W*k +: DATA_W]  = pdata[k];
        end
    endtask

    task automatic setReq(input int idx, input logic [1:0] mode, input logic [7:0] data);
        pend[idx]  = 1'b1;
        pmode[idx] = mode;
        pdata[idx] = data;
    endtask

    task automatic applyStimulus();
        int n;
        int k;
        n = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!pend[j] && $urandom_range(0, 1) == 1) begin
                setReq(j, 2'($urandom_range(0, 3)), 8'($urandom));
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pend[j]) n++;
        end
        if (n == 0) begin
            k = int'($urandom_range(0, NUM_REQ - 1));
            setReq(k, 2'b11, 8'($urandom));
        end
    endtask

    function automatic int expectedWinner();
        int j;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (last_winner + k) % NUM_REQ;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    // Wait for the next grant. exp_wait is the number of non-grant cycles
    // the bench expects before rq_ready fires.
    task automatic waitGrant(output int win);
        int n;
        bit got;
        int ew;
        n   = 0;
        got = 1'b0;
        win = -1;
        while (!got && n <= exp_wait + 16) begin
            @(negedge clk);
            driveReqs();
            spi_idle    = (cyc_r >= idle_low);
            spi_done_tx = noise && ($urandom_range(0, 3) == 0);
            spi_done_rx = noise && ($urandom_range(0, 3) == 0);
            spi_dout    = 8'($urandom);
            #1;
            if (rq_ready != '0) begin
                got = 1'b1;
            end else begin
                checkOutput("gap_spi_req", 32'(spi_req), 32'd0);
                checkOutput("gap_rsp_valid", 32'(rsp_valid), 32'd0);
                n++;
                cyc_r++;
            end
        end
        checkOutput("grant_wait", 32'(n), 32'(exp_wait));
        if (!got) return;
        seen_ready = rq_ready;
        ew = expectedWinner();
        if (ew < 0) begin
            checkOutput("grant_unexpected", 32'(rq_ready), 32'd0);
            return;
        end
        checkOutput("grant_onehot", 32'(rq_ready), 32'd1 << ew);
        checkOutput("grant_busy", 32'(busy), 32'd0);
        win         = ew;
        last_winner = ew;
        pend[ew]    = 1'b0;
    endtask

    // One full transaction. tx_d/rx_d are the issue-cycle indices of the
    // done pulses (negative: never). idle_l is how many gap cycles spi_idle
    // stays low after the response.
    task automatic runTxn(input int tx_d, input int rx_d, input int idle_l,
                          input logic [7:0] sword, output int win);
        int         c;
        int         e;
        logic [1:0] m;
        logic [7:0] d;
        logic       eerr;
        logic [7:0] edata;
        waitGrant(win);
        if (win < 0) return;
        m = pmode[win];
        d = pdata[win];
        if (m == 2'b00) begin
            e     = 0;
            eerr  = 1'b1;
            edata = 8'h00;
        end else begin
            case (m)
                2'b01:   c = (tx_d < 0) ? NEVER : tx_d;
                2'b10:   c = (rx_d < 0) ? NEVER : rx_d;
                default: c = (tx_d < 0 || rx_d < 0) ? NEVER : ((tx_d > rx_d) ? tx_d : rx_d);
            endcase
            if (c > TIMEOUT - 1) begin
                e     = TIMEOUT;
                eerr  = 1'b1;
                edata = 8'h00;
            end else begin
                e     = c + 1;
                eerr  = 1'b0;
                edata = (m == 2'b01) ? 8'h00 : sword;
            end
        end
        for (int i = 0; i <= e; i++) begin
            @(negedge clk);
            driveReqs();
            spi_done_tx = (m != 2'b00) && (i == tx_d);
            spi_done_rx = (m != 2'b00) && (i == rx_d);
            spi_dout    = (i == rx_d) ? sword : ~sword;
            spi_idle    = (i == e) ? (idle_l == 0) : 1'b0;
            #1;
            if (i < e) begin
                checkOutput("issue_rsp_valid", 32'(rsp_valid), 32'd0);
                checkOutput("issue_spi_req", 32'(spi_req), 32'(m));
                checkOutput("issue_spi_din", 32'(spi_din), 32'(d));
                checkOutput("issue_busy", 32'(busy), 32'd1);
            end else begin
                checkOutput("rsp_valid", 32'(rsp_valid), 32'd1 << win);
                checkOutput("rsp_err", 32'(rsp_err), 32'(eerr));
                checkOutput("rsp_data", 32'(rsp_data), 32'(edata));
                checkOutput("rsp_spi_req", 32'(spi_req), 32'd0);
                checkOutput("rsp_busy", 32'(busy), 32'd1);
            end
        end
        idle_low = idle_l;
        cyc_r    = 1;
        exp_wait = ((GAP_CYCLES > idle_l + 1) ? GAP_CYCLES : idle_l + 1) - 1;
    endtask

    task automatic resetMidIssue();
        int w;
        setReq(3, 2'b10, 8'h99);
        waitGrant(w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            driveReqs();
            spi_done_tx = 1'b0;
            spi_done_rx = 1'b0;
            spi_idle    = 1'b0;
            #1;
            checkOutput("pre_reset_spi_req", 32'(spi_req), 32'd2);
        end
        @(negedge clk);
        rst      = 1'b1;
        spi_idle = 1'b1;
        #1;
        checkOutput("reset_rq_ready", 32'(rq_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_spi_req", 32'(spi_req), 32'd0);
        checkOutput("post_reset_spi_din", 32'(spi_din), 32'd0);
        checkOutput("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("post_reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("post_reset_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("after_reset_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("after_reset_busy", 32'(busy), 32'd0);
        end
        last_winner = NUM_REQ - 1;
        cyc_r       = 0;
        idle_low    = 0;
        exp_wait    = 0;
    endtask

    initial begin
        int w;
        int tx_d;
        int rx_d;
        int rr_exp [5];
        rr_exp = '{0, 1, 2, 3, 0};

        for (int k = 0; k < NUM_REQ; k++) begin
            pend[k]  = 1'b0;
            pmode[k] = 2'b00;
            pdata[k] = 8'h00;
        end
        noise       = 1'b0;
        rst         = 1'b1;
        spi_idle    = 1'b1;
        spi_done_tx = 1'b0;
        spi_done_rx = 1'b0;
        spi_dout    = '0;
        driveReqs();

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_spi_req", 32'(spi_req), 32'd0);
        checkOutput("reset_spi_din", 32'(spi_din), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rq_ready", 32'(rq_ready), 32'd0);
        checkOutput("wait_duration", 32'(spi_wait_duration), 32'(WAIT_DURATION));
        @(negedge clk);
        rst         = 1'b0;
        last_winner = NUM_REQ - 1;
        cyc_r       = 0;
        idle_low    = 0;
        exp_wait    = 0;

        // Single tx on req0: the slave word must not appear in the response.
        setReq(0, 2'b01, 8'hA5);
        runTxn(3, 3, 0, 8'hA5, w);
        // Rx on req1 with spi_idle held low for part of the gap.
        setReq(1, 2'b10, 8'h00);
        runTxn(-1, 5, 2, 8'h3C, w);
        // Illegal mode on req2.
        setReq(2, 2'b00, 8'h12);
        runTxn(-1, -1, 0, 8'h00, w);
        // Duplex with both done pulses in the same cycle.
        setReq(3, 2'b11, 8'h5E);
        runTxn(4, 4, 1, 8'hC3, w);
        // Duplex with done pulses 20 cycles apart.
        setReq(0, 2'b11, 8'h81);
        runTxn(2, 22, 0, 8'h5A, w);
        // Timeout with no done pulses.
        setReq(1, 2'b11, 8'h44);
        runTxn(-1, -1, 0, 8'h00, w);
        // Completion on the timeout cycle wins.
        setReq(2, 2'b01, 8'h66);
        runTxn(TIMEOUT - 1, -1, 3, 8'h00, w);
        // Duplex finishing one cycle before the timeout cycle.
        setReq(0, 2'b11, 8'h2D);
        runTxn(10, TIMEOUT - 2, 0, 8'hE7, w);

        resetMidIssue();

        // All requesters continuously pending: strict rotation from req0.
        for (int k = 0; k < NUM_REQ; k++) begin
            setReq(k, 2'(k % 3 + 1), 8'(16 * k + 1));
        end
        for (int k = 0; k < 5; k++) begin
            seen_ready = '0;
            runTxn(1, 1, 0, 8'h11, w);
            checkOutput("rr_order", 32'(seen_ready), 32'd1 << rr_exp[k]);
            if (w >= 0) pend[w] = 1'b1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            pend[k] = 1'b0;
        end

        // Random traffic with stray done pulses during gap and idle cycles.
        noise = 1'b1;
        for (int t = 0; t < 30; t++) begin
            applyStimulus();
            tx_d = int'($urandom_range(0, 20));
            rx_d = ($urandom_range(0, 3) == 0) ? tx_d : int'($urandom_range(0, 20));
            if ($urandom_range(0, 9) == 0) tx_d = -1;
            runTxn(tx_d, rx_d, int'($urandom_range(0, 6)), 8'($urandom), w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
